// File: rtl/fc_credit_receiver.sv
// Receive-side flow-control credit tracker: InitFC sequence, then UpdateFC requests on buffer release.
// Optional overflow detection is built when FC_OVERFLOW_CHECK_EN is defined.
module fc_credit_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tlp_valid,
  input  logic [1:0]            tlp_type,
  input  logic [DATA_WIDTH-1:0] tlp_hdr_credits,
  input  logic [DATA_WIDTH-1:0] tlp_data_credits,
  input  logic                  rel_valid,
  input  logic [1:0]            rel_type,
  input  logic [DATA_WIDTH-1:0] rel_hdr_credits,
  input  logic [DATA_WIDTH-1:0] rel_data_credits,
  output logic                  fc_valid,
  input  logic                  fc_ready,
  output logic                  fc_init,
  output logic [1:0]            fc_type,
  output logic [DATA_WIDTH-1:0] fc_hdr_fc,
  output logic [DATA_WIDTH-1:0] fc_data_fc,
  output logic                  fc_init_done,
  output logic                  fc_error
);

  localparam logic [2:0] INIT_P   = 3'd0;
  localparam logic [2:0] INIT_NP  = 3'd1;
  localparam logic [2:0] INIT_CPL = 3'd2;
  localparam logic [2:0] IDLE     = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;

  localparam logic [DATA_WIDTH-1:0] INIT_CREDITS = DATA_WIDTH'(FIFO_DEPTH);

  logic [2:0]            state;
  logic                  started;
  logic [DATA_WIDTH-1:0] ca_hdr  [3];
  logic [DATA_WIDTH-1:0] ca_data [3];
  logic [DATA_WIDTH-1:0] cr_hdr  [3];
  logic [DATA_WIDTH-1:0] cr_data [3];
  logic [2:0]            pending;
  logic [2:0]            pending_n;
  logic [1:0]            cap_type;
  logic [DATA_WIDTH-1:0] cap_hdr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  init_done_r;
  logic                  init_phase;
  logic                  capture;
  logic [1:0]            sel;
  logic [DATA_WIDTH-1:0] init_hdr;
  logic [DATA_WIDTH-1:0] init_data;
  logic [DATA_WIDTH-1:0] sel_hdr;
  logic [DATA_WIDTH-1:0] sel_data;

  // InitFC fields follow the live CA; UpdateFC fields are frozen at capture.
  assign init_phase   = (state == INIT_P) || (state == INIT_NP) || (state == INIT_CPL);
  assign fc_init      = init_phase && started;
  assign fc_valid     = fc_init || (state == SEND);
  assign fc_type      = fc_init ? state[1:0] : cap_type;
  assign fc_hdr_fc    = fc_init ? init_hdr : cap_hdr;
  assign fc_data_fc   = fc_init ? init_data : cap_data;
  assign fc_init_done = init_done_r;
  assign capture      = (state == IDLE) && (|pending);
  assign sel          = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);

  always_comb begin
    init_hdr  = '0;
    init_data = '0;
    sel_hdr   = '0;
    sel_data  = '0;
    pending_n = pending;
    for (int i = 0; i < 3; i++) begin
      if (state[1:0] == 2'(i)) begin
        init_hdr  = ca_hdr[i];
        init_data = ca_data[i];
      end
      if (sel == 2'(i)) begin
        sel_hdr  = ca_hdr[i];
        sel_data = ca_data[i];
      end
      if (capture && sel == 2'(i)) pending_n[i] = 1'b0;
    end
    // A release landing on the capture edge re-arms the flag after the clear.
    for (int i = 0; i < 3; i++) begin
      if (rel_valid && rel_type == 2'(i)) pending_n[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        ca_hdr[i]  <= INIT_CREDITS;
        ca_data[i] <= INIT_CREDITS;
        cr_hdr[i]  <= '0;
        cr_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rel_valid && rel_type == 2'(i)) begin
          ca_hdr[i]  <= ca_hdr[i] + rel_hdr_credits;
          ca_data[i] <= ca_data[i] + rel_data_credits;
        end
        if (tlp_valid && tlp_type == 2'(i)) begin
          cr_hdr[i]  <= cr_hdr[i] + tlp_hdr_credits;
          cr_data[i] <= cr_data[i] + tlp_data_credits;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT_P;
      started     <= 1'b0;
      pending     <= '0;
      cap_type    <= 2'd0;
      cap_hdr     <= '0;
      cap_data    <= '0;
      init_done_r <= 1'b0;
    end else begin
      started <= 1'b1;
      pending <= pending_n;
      case (state)
        INIT_P:   if (fc_valid && fc_ready) state <= INIT_NP;
        INIT_NP:  if (fc_valid && fc_ready) state <= INIT_CPL;
        INIT_CPL: begin
          if (fc_valid && fc_ready) begin
            state       <= IDLE;
            init_done_r <= 1'b1;
          end
        end
        IDLE: begin
          if (capture) begin
            state    <= SEND;
            cap_type <= sel;
            cap_hdr  <= sel_hdr;
            cap_data <= sel_data;
          end
        end
        SEND:     if (fc_ready) state <= IDLE;
        default:  state <= INIT_P;
      endcase
    end
  end

`ifdef FC_OVERFLOW_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] HALF = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic over_limit(input logic [DATA_WIDTH-1:0] ca,
                                      input logic [DATA_WIDTH-1:0] cr);
    logic [DATA_WIDTH-1:0] diff;
    diff = ca - cr;
    return diff > HALF;
  endfunction

  logic ovf;
  logic error_r;

  // Compare against CA including any release applied on the same edge.
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (tlp_valid && tlp_type == 2'(i)) begin
        if (over_limit(ca_hdr[i] + ((rel_valid && rel_type == 2'(i)) ? rel_hdr_credits : '0),
                       cr_hdr[i] + tlp_hdr_credits))
          ovf = 1'b1;
        if (over_limit(ca_data[i] + ((rel_valid && rel_type == 2'(i)) ? rel_data_credits : '0),
                       cr_data[i] + tlp_data_credits))
          ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   error_r <= 1'b0;
    else if (ovf) error_r <= 1'b1;
  end

  assign fc_error = error_r;
`else
  logic unused_cr;
  assign unused_cr = ^{cr_hdr[0], cr_hdr[1], cr_hdr[2], cr_data[0], cr_data[1], cr_data[2]};
  assign fc_error  = 1'b0;
`endif

endmodule

// File: tb/tb_fc_credit_receiver.sv
// Directed bench for fc_credit_receiver: InitFC, UpdateFC latency/stall/priority, wrap, overflow, reset abort.
module tb_fc_credit_receiver;

`ifdef FC_OVERFLOW_CHECK_EN
  localparam logic [31:0] OVF = 32'd1;
`else
  localparam logic [31:0] OVF = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tlp_valid = 1'b0;
  logic [1:0] tlp_type = 2'd0;
  logic [7:0] tlp_hdr_credits = 8'd0;
  logic [7:0] tlp_data_credits = 8'd0;
  logic       rel_valid = 1'b0;
  logic [1:0] rel_type = 2'd0;
  logic [7:0] rel_hdr_credits = 8'd0;
  logic [7:0] rel_data_credits = 8'd0;
  logic       fc_valid;
  logic       fc_ready = 1'b0;
  logic       fc_init;
  logic [1:0] fc_type;
  logic [7:0] fc_hdr_fc;
  logic [7:0] fc_data_fc;
  logic       fc_init_done;
  logic       fc_error;

  int n_cmp  = 0;
  int n_fail = 0;

  fc_credit_receiver #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .tlp_valid(tlp_valid), .tlp_type(tlp_type),
    .tlp_hdr_credits(tlp_hdr_credits), .tlp_data_credits(tlp_data_credits),
    .rel_valid(rel_valid), .rel_type(rel_type),
    .rel_hdr_credits(rel_hdr_credits), .rel_data_credits(rel_data_credits),
    .fc_valid(fc_valid), .fc_ready(fc_ready), .fc_init(fc_init), .fc_type(fc_type),
    .fc_hdr_fc(fc_hdr_fc), .fc_data_fc(fc_data_fc),
    .fc_init_done(fc_init_done), .fc_error(fc_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rel(input logic [1:0] t, input logic [7:0] h, input logic [7:0] d);
    rel_valid = 1'b1; rel_type = t; rel_hdr_credits = h; rel_data_credits = d;
  endtask

  task automatic tlp(input logic [1:0] t, input logic [7:0] h, input logic [7:0] d);
    tlp_valid = 1'b1; tlp_type = t; tlp_hdr_credits = h; tlp_data_credits = d;
  endtask

  task automatic req(input string tag, input logic [31:0] init, input logic [31:0] typ,
                     input logic [31:0] h, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(fc_valid), 32'd1);
    chk({tag, "_init"}, 32'(fc_init), init);
    chk({tag, "_type"}, 32'(fc_type), typ);
    chk({tag, "_hdr"}, 32'(fc_hdr_fc), h);
    chk({tag, "_data"}, 32'(fc_data_fc), d);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(fc_valid), 32'd0);
    chk("rst_hdr", 32'(fc_hdr_fc), 32'd0);
    chk("rst_done", 32'(fc_init_done), 32'd0);
    chk("rst_error", 32'(fc_error), 32'd0);
    step();
    step();
    chk("rst_hold_valid", 32'(fc_valid), 32'd0);

    // InitFC sequence on three consecutive cycles
    rst_n = 1'b1;
    fc_ready = 1'b1;
    step();
    req("initP", 1, 0, 16, 16);
    chk("initP_done", 32'(fc_init_done), 32'd0);
    step();
    req("initNP", 1, 1, 16, 16);
    step();
    req("initCpl", 1, 2, 16, 16);
    chk("initCpl_done", 32'(fc_init_done), 32'd0);
    step();
    chk("idle_valid", 32'(fc_valid), 32'd0);
    chk("init_done", 32'(fc_init_done), 32'd1);

    // UpdateFC two cycles after release
    rel(2'd0, 8'd2, 8'd4);
    step();
    rel_valid = 1'b0;
    chk("upd_lat1", 32'(fc_valid), 32'd0);
    step();
    req("updP", 0, 0, 18, 20);
    step();
    chk("updP_done", 32'(fc_valid), 32'd0);

    // Stall with P pending, Cpl queued, and a P re-release during SEND
    fc_ready = 1'b0;
    rel(2'd0, 8'd1, 8'd1);
    step();
    rel(2'd2, 8'd3, 8'd5);
    step();
    req("stallP", 0, 0, 19, 21);
    rel(2'd0, 8'd1, 8'd0);
    step();
    rel_valid = 1'b0;
    req("stall1", 0, 0, 19, 21);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_type", 32'(fc_type), 32'd0);
      chk("stall_hdr", 32'(fc_hdr_fc), 32'd19);
      chk("stall_valid", 32'(fc_valid), 32'd1);
    end
    fc_ready = 1'b1;
    step();
    chk("hs_idle", 32'(fc_valid), 32'd0);
    step();
    req("reP", 0, 0, 20, 21);
    step();
    chk("reP_idle", 32'(fc_valid), 32'd0);
    step();
    req("updCpl", 0, 2, 19, 21);
    step();
    chk("cpl_idle", 32'(fc_valid), 32'd0);

    // Reserved type ignored on both inputs
    rel(2'd3, 8'd50, 8'd50);
    tlp(2'd3, 8'd200, 8'd200);
    step();
    rel_valid = 1'b0;
    tlp_valid = 1'b0;
    step();
    chk("rsv_valid", 32'(fc_valid), 32'd0);
    chk("rsv_error", 32'(fc_error), 32'd0);

    // CA wrap: 20 + 230 = 250, then + 10 = 4
    rel(2'd0, 8'd230, 8'd0);
    step();
    rel_valid = 1'b0;
    step();
    req("wrap250", 0, 0, 250, 21);
    step();
    rel(2'd0, 8'd10, 8'd0);
    step();
    rel_valid = 1'b0;
    step();
    req("wrap4", 0, 0, 4, 21);
    step();

    // Overflow: Cpl distance exactly half is legal, NP beyond CA is not
    tlp(2'd2, 8'd147, 8'd0);
    step();
    tlp_valid = 1'b0;
    chk("ovf_half", 32'(fc_error), 32'd0);
    tlp(2'd1, 8'd16, 8'd16);
    step();
    tlp_valid = 1'b0;
    chk("ovf_full", 32'(fc_error), 32'd0);
    tlp(2'd1, 8'd1, 8'd0);
    step();
    tlp_valid = 1'b0;
    chk("ovf_set", 32'(fc_error), OVF);
    step();
    step();
    chk("ovf_sticky", 32'(fc_error), OVF);
    chk("ovf_noreq", 32'(fc_valid), 32'd0);

    // Reset while SEND is stalled aborts the request
    fc_ready = 1'b0;
    rel(2'd0, 8'd1, 8'd1);
    step();
    rel_valid = 1'b0;
    step();
    req("pre_rst", 0, 0, 5, 22);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(fc_valid), 32'd0);
    chk("abort_done", 32'(fc_init_done), 32'd0);
    chk("abort_error", 32'(fc_error), 32'd0);
    chk("abort_hdr", 32'(fc_hdr_fc), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    req("reinitP", 1, 0, 16, 16);
    step();
    req("reinitP_hold", 1, 0, 16, 16);
    fc_ready = 1'b1;
    step();
    req("reinitNP", 1, 1, 16, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
